// File: rtl/mpf_svc_vtp_tag_tracker.sv
// Tag tracker between a VTP shim channel and the translation service.
// Allocates tags, issues virtual lookups in order and returns completions out of order by tag.
module mpf_svc_vtp_tag_tracker #(
    parameter int unsigned N_TAGS = 16,
    parameter int unsigned ADDR_W = 42,
    localparam int unsigned TAG_W = $clog2(N_TAGS)
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              req_en,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_addr_is_virtual,
    input  logic              req_is_speculative,
    input  logic              req_is_ordered,
    output logic              not_full,
    output logic [TAG_W-1:0]  req_idx,

    output logic              svc_req_valid,
    input  logic              svc_req_ready,
    output logic [ADDR_W-1:0] svc_req_addr,
    output logic [TAG_W-1:0]  svc_req_tag,
    output logic              svc_req_is_speculative,

    input  logic              svc_rsp_valid,
    input  logic [TAG_W-1:0]  svc_rsp_tag,
    input  logic [ADDR_W-1:0] svc_rsp_addr,
    input  logic              svc_rsp_error,

    output logic              rsp_valid,
    output logic [TAG_W-1:0]  rsp_idx,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              rsp_addr_is_virtual,
    output logic              rsp_error,
    input  logic              rsp_deq_en
);

    localparam int unsigned PTR_W = TAG_W + 1;

    logic [N_TAGS-1:0] free_q;
    logic [N_TAGS-1:0] at_svc_q;

    // Per-tag table: holds the request address until completion overwrites it with the result
    logic [ADDR_W-1:0] addr_q [N_TAGS];
    logic [N_TAGS-1:0] virt_q;
    logic [N_TAGS-1:0] spec_q;
    logic [N_TAGS-1:0] err_q;

    logic [TAG_W-1:0]  iss_q [N_TAGS];
    logic [PTR_W-1:0]  iss_wr_q, iss_rd_q;
    logic [TAG_W-1:0]  cmp_q [N_TAGS];
    logic [PTR_W-1:0]  cmp_wr_q, cmp_rd_q;

    logic             any_free, all_free, accept, deq, rsp_in;
    logic             iss_empty, head_virt, svc_fire, phys_pop, iss_pop, cmp_push;
    logic [TAG_W-1:0] iss_head, cmp_tag;

    // Lowest-numbered free tag
    always_comb begin
        req_idx = '0;
        for (int i = N_TAGS - 1; i >= 0; i--) begin
            if (free_q[i]) req_idx = TAG_W'(i);
        end
    end

    always_comb begin
        any_free  = |free_q;
        all_free  = &free_q;
        not_full  = reset_n && any_free && (!req_is_ordered || all_free);
        accept    = req_en && not_full;
        rsp_in    = svc_rsp_valid && reset_n;

        iss_empty = (iss_wr_q == iss_rd_q);
        iss_head  = iss_q[iss_rd_q[TAG_W-1:0]];
        head_virt = virt_q[iss_head];

        svc_req_valid          = !iss_empty && head_virt;
        svc_req_tag            = iss_head;
        svc_req_addr           = addr_q[iss_head];
        svc_req_is_speculative = spec_q[iss_head];
        svc_fire               = svc_req_valid && svc_req_ready;

        // A physical head yields the completion slot to a service response
        phys_pop = !iss_empty && !head_virt && !rsp_in;
        iss_pop  = svc_fire || phys_pop;
        cmp_push = rsp_in || phys_pop;
        cmp_tag  = rsp_in ? svc_rsp_tag : iss_head;

        rsp_valid           = (cmp_wr_q != cmp_rd_q);
        rsp_idx             = cmp_q[cmp_rd_q[TAG_W-1:0]];
        rsp_addr            = addr_q[rsp_idx];
        rsp_addr_is_virtual = virt_q[rsp_idx];
        rsp_error           = err_q[rsp_idx];
        deq                 = rsp_deq_en && rsp_valid;
    end

    // Free vector, FIFO pointers and service-occupancy tracking
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            free_q   <= '1;
            at_svc_q <= '0;
            iss_wr_q <= '0;
            iss_rd_q <= '0;
            cmp_wr_q <= '0;
            cmp_rd_q <= '0;
        end else begin
            if (accept)   free_q[req_idx]       <= 1'b0;
            if (deq)      free_q[rsp_idx]       <= 1'b1;
            if (svc_fire) at_svc_q[svc_req_tag] <= 1'b1;
            if (rsp_in)   at_svc_q[svc_rsp_tag] <= 1'b0;
            if (accept)   iss_wr_q <= iss_wr_q + PTR_W'(1);
            if (iss_pop)  iss_rd_q <= iss_rd_q + PTR_W'(1);
            if (cmp_push) cmp_wr_q <= cmp_wr_q + PTR_W'(1);
            if (deq)      cmp_rd_q <= cmp_rd_q + PTR_W'(1);
        end
    end

    // Storage arrays; entries are only read once their FIFO pointers cover them
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q[req_idx]              <= req_addr;
            virt_q[req_idx]              <= req_addr_is_virtual;
            spec_q[req_idx]              <= req_is_speculative;
            err_q[req_idx]               <= 1'b0;
            iss_q[iss_wr_q[TAG_W-1:0]]   <= req_idx;
        end
        if (rsp_in) begin
            if (svc_rsp_error) begin
                err_q[svc_rsp_tag] <= 1'b1;
            end else begin
                addr_q[svc_rsp_tag] <= svc_rsp_addr;
                virt_q[svc_rsp_tag] <= 1'b0;
            end
        end
        if (cmp_push) cmp_q[cmp_wr_q[TAG_W-1:0]] <= cmp_tag;
    end

    // Protocol checks
    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (!(req_en && !not_full))
                else $fatal(1, "req_en asserted while not_full is low");
            assert (!(rsp_deq_en && !rsp_valid))
                else $fatal(1, "rsp_deq_en asserted while rsp_valid is low");
            assert (!(svc_rsp_valid && !at_svc_q[svc_rsp_tag]))
                else $fatal(1, "svc_rsp_tag %0d is not outstanding at the service", svc_rsp_tag);
        end
    end

endmodule

// File: tb/tb_mpf_svc_vtp_tag_tracker.sv
// Directed self-checking bench for mpf_svc_vtp_tag_tracker.
module tb_mpf_svc_vtp_tag_tracker;

    localparam int unsigned N_TAGS = 16;
    localparam int unsigned ADDR_W = 42;
    localparam int unsigned TAG_W  = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              req_en, req_addr_is_virtual, req_is_speculative, req_is_ordered;
    logic [ADDR_W-1:0] req_addr;
    logic              not_full;
    logic [TAG_W-1:0]  req_idx;
    logic              svc_req_valid, svc_req_ready, svc_req_is_speculative;
    logic [ADDR_W-1:0] svc_req_addr;
    logic [TAG_W-1:0]  svc_req_tag;
    logic              svc_rsp_valid, svc_rsp_error;
    logic [TAG_W-1:0]  svc_rsp_tag;
    logic [ADDR_W-1:0] svc_rsp_addr;
    logic              rsp_valid, rsp_addr_is_virtual, rsp_error, rsp_deq_en;
    logic [TAG_W-1:0]  rsp_idx;
    logic [ADDR_W-1:0] rsp_addr;

    int tests_run    = 0;
    int tests_failed = 0;

    mpf_svc_vtp_tag_tracker #(.N_TAGS(N_TAGS), .ADDR_W(ADDR_W)) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .req_en                 (req_en),
        .req_addr               (req_addr),
        .req_addr_is_virtual    (req_addr_is_virtual),
        .req_is_speculative     (req_is_speculative),
        .req_is_ordered         (req_is_ordered),
        .not_full               (not_full),
        .req_idx                (req_idx),
        .svc_req_valid          (svc_req_valid),
        .svc_req_ready          (svc_req_ready),
        .svc_req_addr           (svc_req_addr),
        .svc_req_tag            (svc_req_tag),
        .svc_req_is_speculative (svc_req_is_speculative),
        .svc_rsp_valid          (svc_rsp_valid),
        .svc_rsp_tag            (svc_rsp_tag),
        .svc_rsp_addr           (svc_rsp_addr),
        .svc_rsp_error          (svc_rsp_error),
        .rsp_valid              (rsp_valid),
        .rsp_idx                (rsp_idx),
        .rsp_addr               (rsp_addr),
        .rsp_addr_is_virtual    (rsp_addr_is_virtual),
        .rsp_error              (rsp_error),
        .rsp_deq_en             (rsp_deq_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are probed 2 units later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic probe();
        #2;
    endtask

    task automatic idle();
        req_en              = 1'b0;
        req_addr            = '0;
        req_addr_is_virtual = 1'b0;
        req_is_speculative  = 1'b0;
        req_is_ordered      = 1'b0;
        svc_rsp_valid       = 1'b0;
        svc_rsp_tag         = '0;
        svc_rsp_addr        = '0;
        svc_rsp_error       = 1'b0;
        rsp_deq_en          = 1'b0;
    endtask

    task automatic accept(input logic [ADDR_W-1:0] addr, input logic virt, input logic ordered,
                          input logic [TAG_W-1:0] exp_tag, input string name);
        req_en              = 1'b1;
        req_addr            = addr;
        req_addr_is_virtual = virt;
        req_is_ordered      = ordered;
        probe();
        chk({name, "_not_full"}, 64'(not_full), 64'(1));
        chk({name, "_idx"}, 64'(req_idx), 64'(exp_tag));
        step();
        idle();
    endtask

    initial begin
        idle();
        svc_req_ready = 1'b1;
        reset_n       = 1'b0;
        step();
        step();
        probe();
        chk("rst_not_full", 64'(not_full), 64'(0));
        chk("rst_svc_valid", 64'(svc_req_valid), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_req_idx", 64'(req_idx), 64'(0));
        reset_n = 1'b1;
        step();
        probe();
        chk("post_rst_not_full", 64'(not_full), 64'(1));
        chk("post_rst_req_idx", 64'(req_idx), 64'(0));
        chk("post_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        step();

        // Physical pass-through: completes two cycles after accept, never touches the service
        accept(42'h123, 1'b0, 1'b0, 4'd0, "phys");
        probe();
        chk("phys_t1_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("phys_t1_svc_valid", 64'(svc_req_valid), 64'(0));
        step();
        probe();
        chk("phys_t2_rsp_valid", 64'(rsp_valid), 64'(1));
        chk("phys_idx", 64'(rsp_idx), 64'(0));
        chk("phys_addr", 64'(rsp_addr), 64'h123);
        chk("phys_virt", 64'(rsp_addr_is_virtual), 64'(0));
        chk("phys_err", 64'(rsp_error), 64'(0));
        chk("phys_t2_svc_valid", 64'(svc_req_valid), 64'(0));
        rsp_deq_en = 1'b1;
        step();
        idle();
        probe();
        chk("phys_drained", 64'(rsp_valid), 64'(0));
        step();

        // Fill the pool with virtual requests; issue trails accept by one cycle
        for (int i = 0; i < 16; i++) begin
            req_en              = 1'b1;
            req_addr            = ADDR_W'(i);
            req_addr_is_virtual = 1'b1;
            probe();
            chk("fill_idx", 64'(req_idx), 64'(i));
            chk("fill_not_full", 64'(not_full), 64'(1));
            if (i == 1 || i == 9) begin
                chk("fill_svc_valid", 64'(svc_req_valid), 64'(1));
                chk("fill_svc_tag", 64'(svc_req_tag), 64'(i - 1));
                chk("fill_svc_addr", 64'(svc_req_addr), 64'(i - 1));
            end
            step();
        end
        idle();
        probe();
        chk("full_not_full", 64'(not_full), 64'(0));
        chk("full_svc_tag", 64'(svc_req_tag), 64'(15));
        step();

        // Return tags 15..0, dequeue each the cycle after; tag 15 is reused at once
        for (int c = 0; c <= 16; c++) begin
            svc_rsp_valid = (c <= 15);
            svc_rsp_tag   = TAG_W'(15 - c);
            svc_rsp_addr  = ADDR_W'(32'h1000 + 15 - c);
            rsp_deq_en    = (c >= 1);
            if (c == 2) begin
                req_en              = 1'b1;
                req_addr            = 42'h777;
                req_addr_is_virtual = 1'b0;
            end
            probe();
            if (c == 0) begin
                chk("ooo_first_rsp_valid", 64'(rsp_valid), 64'(0));
            end else begin
                chk("ooo_rsp_idx", 64'(rsp_idx), 64'(16 - c));
                chk("ooo_rsp_addr", 64'(rsp_addr), 64'(32'h1000 + 16 - c));
            end
            if (c == 1) chk("ooo_still_full", 64'(not_full), 64'(0));
            if (c == 2) begin
                chk("ooo_reopen_not_full", 64'(not_full), 64'(1));
                chk("ooo_reuse_idx", 64'(req_idx), 64'(15));
            end
            step();
            idle();
        end
        probe();
        chk("ooo_phys_valid", 64'(rsp_valid), 64'(1));
        chk("ooo_phys_idx", 64'(rsp_idx), 64'(15));
        chk("ooo_phys_addr", 64'(rsp_addr), 64'h777);
        chk("ooo_phys_virt", 64'(rsp_addr_is_virtual), 64'(0));
        rsp_deq_en = 1'b1;
        step();
        idle();
        probe();
        chk("ooo_drained", 64'(rsp_valid), 64'(0));
        step();

        // Ordered request waits for all three outstanding tags to be dequeued
        accept(42'h10, 1'b1, 1'b0, 4'd0, "ord_a");
        accept(42'h11, 1'b1, 1'b0, 4'd1, "ord_b");
        accept(42'h12, 1'b1, 1'b0, 4'd2, "ord_c");
        for (int k = 0; k <= 4; k++) begin
            req_is_ordered = 1'b1;
            svc_rsp_valid  = (k >= 1 && k <= 3);
            svc_rsp_tag    = TAG_W'(k - 1);
            svc_rsp_addr   = ADDR_W'(32'h2000 + k);
            rsp_deq_en     = (k >= 2);
            probe();
            chk("ord_blocked", 64'(not_full), 64'(0));
            if (k >= 2) chk("ord_rsp_idx", 64'(rsp_idx), 64'(k - 2));
            step();
            idle();
        end
        req_is_speculative = 1'b1;
        accept(42'hABCDE, 1'b1, 1'b1, 4'd0, "ord_go");

        // Translation error returns the original VA flagged virtual
        probe();
        chk("err_svc_valid", 64'(svc_req_valid), 64'(1));
        chk("err_svc_tag", 64'(svc_req_tag), 64'(0));
        chk("err_svc_addr", 64'(svc_req_addr), 64'hABCDE);
        chk("err_svc_spec", 64'(svc_req_is_speculative), 64'(1));
        step();
        svc_rsp_valid = 1'b1;
        svc_rsp_tag   = 4'd0;
        svc_rsp_addr  = 42'h3FF;
        svc_rsp_error = 1'b1;
        step();
        idle();
        probe();
        chk("err_rsp_valid", 64'(rsp_valid), 64'(1));
        chk("err_rsp_addr", 64'(rsp_addr), 64'hABCDE);
        chk("err_rsp_virt", 64'(rsp_addr_is_virtual), 64'(1));
        chk("err_rsp_error", 64'(rsp_error), 64'(1));
        rsp_deq_en = 1'b1;
        step();
        idle();

        // Collision: physical head waits one cycle behind a service response
        accept(42'h4000, 1'b1, 1'b0, 4'd0, "col_a");
        accept(42'h4001, 1'b1, 1'b0, 4'd1, "col_b");
        accept(42'h4002, 1'b1, 1'b0, 4'd2, "col_c");
        accept(42'h5003, 1'b0, 1'b0, 4'd3, "col_p");
        svc_rsp_valid = 1'b1;
        svc_rsp_tag   = 4'd2;
        svc_rsp_addr  = 42'h6002;
        probe();
        chk("col_svc_valid", 64'(svc_req_valid), 64'(0));
        chk("col_rsp_empty", 64'(rsp_valid), 64'(0));
        step();
        idle();
        probe();
        chk("col_first_valid", 64'(rsp_valid), 64'(1));
        chk("col_first_idx", 64'(rsp_idx), 64'(2));
        chk("col_first_addr", 64'(rsp_addr), 64'h6002);
        rsp_deq_en = 1'b1;
        step();
        idle();
        probe();
        chk("col_second_valid", 64'(rsp_valid), 64'(1));
        chk("col_second_idx", 64'(rsp_idx), 64'(3));
        chk("col_second_addr", 64'(rsp_addr), 64'h5003);
        rsp_deq_en = 1'b1;
        step();
        idle();

        // Mid-operation reset with five tags in flight and a response presented during reset
        accept(42'h7002, 1'b1, 1'b0, 4'd2, "mid_a");
        accept(42'h7003, 1'b1, 1'b0, 4'd3, "mid_b");
        accept(42'h7004, 1'b1, 1'b0, 4'd4, "mid_c");
        step();
        reset_n       = 1'b0;
        svc_rsp_valid = 1'b1;
        svc_rsp_tag   = 4'd0;
        svc_rsp_addr  = 42'h8000;
        probe();
        chk("mid_rst_not_full", 64'(not_full), 64'(0));
        step();
        idle();
        reset_n = 1'b1;
        probe();
        chk("mid_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("mid_not_full", 64'(not_full), 64'(1));
        chk("mid_svc_valid", 64'(svc_req_valid), 64'(0));
        chk("mid_req_idx", 64'(req_idx), 64'(0));
        step();
        accept(42'h99, 1'b0, 1'b0, 4'd0, "mid_new");
        step();
        probe();
        chk("mid_new_valid", 64'(rsp_valid), 64'(1));
        chk("mid_new_idx", 64'(rsp_idx), 64'(0));
        chk("mid_new_addr", 64'(rsp_addr), 64'h99);
        rsp_deq_en = 1'b1;
        step();
        idle();
        probe();
        chk("mid_drained", 64'(rsp_valid), 64'(0));
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
